// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Arbitrates one single-port, synchronous-read VRAM between the
//             render fetch engine (BURST-byte bursts) and the CPU data port
//             (single-byte reads/writes). Ties alternate so CPU waits at most
//             one render burst.
//  Ports    :
//    clk_100, rst_L                 clock, async active-low reset
//    ren_req/ren_addr               render burst request + base address
//    ren_ack/ren_data/ren_valid     grant pulse, burst result, result strobe
//    cpu_req/cpu_we/cpu_addr/
//    cpu_wdata                      CPU access request
//    cpu_ack/cpu_rdata/cpu_rvalid   grant pulse, read data, read strobe
//    ram_en/ram_we/ram_addr/
//    ram_wdata/ram_rdata            VRAM port (read latency 1)
//  Revision : 1.0  initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int BURST  = 8
) (
    input  logic                  clk_100,
    input  logic                  rst_L,
    input  logic                  ren_req,
    input  logic [ADDR_W-1:0]     ren_addr,
    output logic                  ren_ack,
    output logic [BURST-1:0][7:0] ren_data,
    output logic                  ren_valid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_ack,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    localparam int                CNT_W           = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0]  c_CNT_LAST_ADDR = CNT_W'(BURST - 1);
    localparam logic [CNT_W-1:0]  c_CNT_LAST_CAP  = CNT_W'(BURST);
    localparam logic [CNT_W-1:0]  c_CNT_ONE       = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE      = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REN      = 2'd1,
        S_CPU_ACC  = 2'd2,
        S_CPU_WAIT = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;        // REN cycle index 0..BURST
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [ADDR_W-1:0]       r_base;       // burst base latched on grant
    logic                    r_last_ren;   // 1: last grant went to render
    logic [BURST-1:0][7:0]   r_shadow;     // bytes collected during a burst
    logic [BURST-1:0][7:0]   w_shadow_nxt;

    logic                    w_grant_ren;
    logic                    w_grant_cpu;
    logic                    w_capture;
    logic                    w_ren_done;
    logic                    w_cpu_rd_done;
    logic                    w_ram_en_nxt;
    logic                    w_ram_we_nxt;
    logic [ADDR_W-1:0]       w_ram_addr_nxt;
    logic [7:0]              w_ram_wdata_nxt;

    // Bytes enter at the top and shift down, so after BURST captures the
    // first-returned byte (base+0) sits in byte lane 0.
    assign w_shadow_nxt = {ram_rdata, r_shadow[BURST-1:1]};

    // Data returned in REN cycle c belongs to the address driven in c-1.
    assign w_capture = (r_state == S_REN) && (r_cnt != '0);

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear one cycle later on the ports.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_grant_ren     = 1'b0;
        w_grant_cpu     = 1'b0;
        w_ren_done      = 1'b0;
        w_cpu_rd_done   = 1'b0;
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = ram_addr;
        w_ram_wdata_nxt = ram_wdata;

        case (r_state)
            S_IDLE: begin
                // On a tie the side that did not win last time gets it.
                if (ren_req && (!cpu_req || !r_last_ren)) begin
                    w_grant_ren    = 1'b1;
                    w_state_nxt    = S_REN;
                    w_cnt_nxt      = '0;
                    w_ram_en_nxt   = 1'b1;
                    w_ram_addr_nxt = ren_addr;
                end else if (cpu_req) begin
                    w_grant_cpu     = 1'b1;
                    w_state_nxt     = S_CPU_ACC;
                    w_ram_en_nxt    = 1'b1;
                    w_ram_we_nxt    = cpu_we;
                    w_ram_addr_nxt  = cpu_addr;
                    w_ram_wdata_nxt = cpu_wdata;
                end
            end

            S_REN: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (r_cnt < c_CNT_LAST_ADDR) begin
                    w_ram_en_nxt   = 1'b1;
                    w_ram_addr_nxt = r_base + ADDR_W'(r_cnt) + c_ADDR_ONE;
                end
                if (r_cnt == c_CNT_LAST_CAP) begin
                    w_ren_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            // ram_we still holds the latched direction of this access.
            S_CPU_ACC: begin
                w_state_nxt = ram_we ? S_IDLE : S_CPU_WAIT;
            end

            S_CPU_WAIT: begin
                w_cpu_rd_done = 1'b1;
                w_state_nxt   = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers. Reset drops any in-flight access and
    // its partially collected burst.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge rst_L) begin
        if (!rst_L) begin
            r_base     <= '0;
            r_last_ren <= 1'b0;
            r_shadow   <= '0;
            ren_ack    <= 1'b0;
            ren_data   <= '0;
            ren_valid  <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            ren_ack    <= w_grant_ren;
            cpu_ack    <= w_grant_cpu;
            ren_valid  <= w_ren_done;
            cpu_rvalid <= w_cpu_rd_done;
            ram_en     <= w_ram_en_nxt;
            ram_we     <= w_ram_we_nxt;
            ram_addr   <= w_ram_addr_nxt;
            ram_wdata  <= w_ram_wdata_nxt;

            if (w_grant_ren) begin
                r_base     <= ren_addr;
                r_last_ren <= 1'b1;
            end else if (w_grant_cpu) begin
                r_last_ren <= 1'b0;
            end

            if (w_capture) begin
                r_shadow <= w_shadow_nxt;
            end
            if (w_ren_done) begin
                ren_data <= w_shadow_nxt;
            end
            if (w_cpu_rd_done) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Self-checking bench for vram_arbiter. A VRAM model answers the
//             RAM port; a golden byte array tracks what VRAM should contain.
//             Grants push expected results into queues; a monitor pops them
//             when ren_valid / cpu_rvalid fire.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int ADDR_W = 14;
    localparam int BURST  = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                  clk_100 = 1'b0;
    logic                  rst_L;
    logic                  ren_req;
    logic [ADDR_W-1:0]     ren_addr;
    logic                  ren_ack;
    logic [BURST-1:0][7:0] ren_data;
    logic                  ren_valid;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [7:0]            cpu_wdata;
    logic                  cpu_ack;
    logic [7:0]            cpu_rdata;
    logic                  cpu_rvalid;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata = 8'h00;

    vram_arbiter #(.ADDR_W(ADDR_W), .BURST(BURST)) dut (
        .clk_100    (clk_100),
        .rst_L      (rst_L),
        .ren_req    (ren_req),
        .ren_addr   (ren_addr),
        .ren_ack    (ren_ack),
        .ren_data   (ren_data),
        .ren_valid  (ren_valid),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk_100 = ~clk_100;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ren_valid_cnt = 0;

    logic [7:0] mem  [0:DEPTH-1];   // VRAM contents seen by the DUT
    logic [7:0] gold [0:DEPTH-1];   // what VRAM should contain

    typedef struct { logic [63:0] d; int due; } exp_t;
    typedef struct { logic we; logic [ADDR_W-1:0] a; logic [7:0] d; int c; } log_t;
    exp_t ren_q[$];
    exp_t cpu_q[$];
    log_t ram_log[$];
    logic log_en = 1'b0;

    always @(posedge clk_100) cyc <= cyc + 1;

    // Synchronous-read VRAM, latency 1, read-before-write.
    always @(posedge clk_100) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] = ram_wdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_100);
        #1;
    endtask

    // ---------------- scoreboard: acceptance + monitor ----------------
    always @(negedge clk_100) begin
        exp_t            e;
        logic [ADDR_W-1:0] a;
        if (ren_ack) begin
            for (int i = 0; i < BURST; i++) begin
                a = ren_addr + ADDR_W'(i);
                e.d[i*8 +: 8] = gold[a];
            end
            e.due = cyc + BURST + 1;
            ren_q.push_back(e);
        end
        if (cpu_ack) begin
            if (cpu_we) begin
                gold[cpu_addr] = cpu_wdata;
            end else begin
                e.d   = {56'b0, gold[cpu_addr]};
                e.due = cyc + 2;
                cpu_q.push_back(e);
            end
        end
        if (ren_valid) begin
            ren_valid_cnt++;
            if (ren_q.size() == 0) begin
                chk("ren_valid unexpected", ren_valid, 1'b0);
            end else begin
                e = ren_q.pop_front();
                chk("ren_data", ren_data, e.d);
                chk("ren_valid cycle", cyc, e.due);
            end
        end
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                chk("cpu_rvalid unexpected", cpu_rvalid, 1'b0);
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", cpu_rdata, e.d);
                chk("cpu_rvalid cycle", cyc, e.due);
            end
        end
        if (ram_we) chk("ram_we outside cpu write grant", {cpu_ack, ram_en}, 2'b11);
        if (log_en && ram_en) ram_log.push_back('{ram_we, ram_addr, ram_wdata, cyc});
    end

    // ---------------- drivers (called just after a rising edge) ----------------
    task automatic ren_grant(input logic [ADDR_W-1:0] a, output int raise_c, output int ack_c);
        ren_addr = a;
        ren_req  = 1'b1;
        raise_c  = cyc;
        ack_c    = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_100);
            if (ren_ack) begin
                ack_c = cyc;
                break;
            end
        end
        if (ack_c < 0) chk("ren_ack wait", ren_ack, 1'b1);
    endtask

    task automatic do_ren(input logic [ADDR_W-1:0] a, output int raise_c, output int ack_c);
        ren_grant(a, raise_c, ack_c);
        tick();
        ren_req = 1'b0;
    endtask

    task automatic do_cpu(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] wd,
                          output int raise_c, output int ack_c);
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        raise_c   = cyc;
        ack_c     = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_100);
            if (cpu_ack) begin
                ack_c = cyc;
                break;
            end
        end
        if (ack_c < 0) chk("cpu_ack wait", cpu_ack, 1'b1);
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic wait_ren_valid(output int vc, output logic [63:0] d);
        vc = -1;
        d  = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_100);
            if (ren_valid) begin
                vc = cyc;
                d  = ren_data;
                break;
            end
        end
        if (vc < 0) chk("ren_valid wait", ren_valid, 1'b1);
    endtask

    task automatic wait_cpu_rvalid(output int vc, output logic [7:0] d);
        vc = -1;
        d  = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_100);
            if (cpu_rvalid) begin
                vc = cyc;
                d  = cpu_rdata;
                break;
            end
        end
        if (vc < 0) chk("cpu_rvalid wait", cpu_rvalid, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int r, k, kc, vc, n, vc0;
        int seq [4];
        logic [63:0] d64;
        logic [7:0]  d8;
        logic [ADDR_W-1:0] ea;
        logic [31:0] v;

        rst_L = 1'b0; ren_req = 1'b0; ren_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mem[i]  = v[7:0];
            gold[i] = v[7:0];
        end
        for (int i = 0; i < BURST; i++) begin
            mem[16'h0100 + i]  = 8'(8'h10 + i);
            gold[16'h0100 + i] = 8'(8'h10 + i);
        end

        // Reset values
        repeat (2) @(negedge clk_100);
        chk("reset ren_ack", ren_ack, 0);
        chk("reset ren_data", ren_data, 0);
        chk("reset ren_valid", ren_valid, 0);
        chk("reset cpu_ack", cpu_ack, 0);
        chk("reset cpu_rdata", cpu_rdata, 0);
        chk("reset cpu_rvalid", cpu_rvalid, 0);
        chk("reset ram_en", ram_en, 0);
        chk("reset ram_we", ram_we, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset ram_wdata", ram_wdata, 0);
        tick();
        rst_L = 1'b1;
        repeat (2) tick();

        // Single burst from a prefilled region
        do_ren(14'h0100, r, k);
        chk("ren_ack at T+1", k - r, 1);
        wait_ren_valid(vc, d64);
        chk("ren_valid at T+10", vc - k, 9);
        chk("burst data", d64, 64'h1716151413121110);
        tick();

        // Address wrap
        ram_log.delete();
        log_en = 1'b1;
        do_ren(14'h3FFC, r, k);
        wait_ren_valid(vc, d64);
        log_en = 1'b0;
        chk("wrap access count", ram_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            ea = 14'h3FFC + ADDR_W'(i);
            if (i < ram_log.size()) chk("wrap ram_addr", ram_log[i].a, ea);
        end
        tick();

        // CPU write then read
        ram_log.delete();
        log_en = 1'b1;
        do_cpu(1'b1, 14'h2000, 8'hA5, r, k);
        repeat (2) tick();
        log_en = 1'b0;
        chk("write access count", ram_log.size(), 1);
        if (ram_log.size() >= 1) begin
            chk("write ram_we", ram_log[0].we, 1'b1);
            chk("write cycle is T+1", ram_log[0].c - k, 0);
            chk("write ram_addr", ram_log[0].a, 14'h2000);
            chk("write ram_wdata", ram_log[0].d, 8'hA5);
        end
        do_cpu(1'b0, 14'h2000, 8'h00, r, k);
        wait_cpu_rvalid(vc, d8);
        chk("cpu_rvalid at T+3", vc - k, 2);
        chk("cpu read-back", d8, 8'hA5);
        tick();

        // CPU request raised at T+3 of a burst
        ren_grant(14'h0100, r, k);
        tick();
        ren_req = 1'b0;
        tick();
        do_cpu(1'b0, 14'h2000, 8'h00, r, kc);
        chk("cpu_ack at T+11", kc - k, 10);
        repeat (5) tick();

        // Reset during REN cycle 4
        ren_grant(14'h0100, r, k);
        repeat (4) tick();
        rst_L   = 1'b0;
        ren_req = 1'b0;
        #1;
        chk("abort ren_data", ren_data, 0);
        chk("abort ram_en", ram_en, 0);
        ren_q.delete();
        vc0 = ren_valid_cnt;
        repeat (3) tick();
        rst_L = 1'b1;
        repeat (12) tick();
        chk("no ren_valid after abort", ren_valid_cnt - vc0, 0);
        do_ren(14'h0100, r, k);
        wait_ren_valid(vc, d64);
        chk("burst after abort", d64, 64'h1716151413121110);
        tick();

        // Fairness with both requests held from reset
        rst_L = 1'b0;
        ren_req = 1'b1; ren_addr = 14'h0100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
        repeat (2) tick();
        rst_L = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int j = 0; j < 80 && n < 4; j++) begin
            @(negedge clk_100);
            if (ren_ack) begin seq[n] = 1; n++; end
            else if (cpu_ack) begin seq[n] = 2; n++; end
        end
        tick();
        ren_req = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) chk("grant order (1=ren 2=cpu)", seq[i], (i % 2 == 0) ? 1 : 2);
        repeat (15) tick();

        // Randomized concurrent traffic
        fork
            begin
                int rr, kk;
                logic [ADDR_W-1:0] a;
                for (int t = 0; t < 20; t++) begin
                    repeat ($urandom_range(0, 6)) tick();
                    a = 14'h1FF8 + ADDR_W'($urandom_range(0, 24));
                    do_ren(a, rr, kk);
                    if (kk >= 0) chk("ren grant latency bound", (kk - rr) <= 4, 1'b1);
                    repeat (9) tick();
                end
            end
            begin
                int rr, kk;
                logic [ADDR_W-1:0] a;
                logic [31:0] w;
                for (int t = 0; t < 40; t++) begin
                    repeat ($urandom_range(0, 4)) tick();
                    a = 14'h2000 + ADDR_W'($urandom_range(0, 15));
                    w = $urandom;
                    do_cpu(w[8], a, w[7:0], rr, kk);
                    if (kk >= 0) chk("cpu grant latency bound", (kk - rr) <= BURST + 3, 1'b1);
                    repeat (2) tick();
                end
            end
        join

        for (int j = 0; j < 60; j++) begin
            if (ren_q.size() == 0 && cpu_q.size() == 0) break;
            @(negedge clk_100);
        end
        chk("scoreboard drained", ren_q.size() + cpu_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
